// File: rtl/match_referee_pkg.sv
// Shared definitions for the match referee: FSM encoding, side constants and
// default match rules.
package match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RALLY = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam logic SIDE_P1 = 1'b0;
    localparam logic SIDE_P2 = 1'b1;

    localparam int DEF_WIN_POINTS  = 15;
    localparam int DEF_MAX_TOUCHES = 3;

    // Touch counters must hold MAX_TOUCHES+1 for the largest legal limit (7).
    localparam int CNT_W = 4;

endpackage

// File: rtl/match_referee_pause.sv
// Post-point pause countdown: load starts a PAUSE_CYCLES-long wait, done is
// high in the final cycle of that wait.
module pause_timer #(
    parameter int PAUSE_CYCLES = 65_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic clear_i,
    output logic done_o
);

    localparam int W = $clog2(PAUSE_CYCLES + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = W'(PAUSE_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/match_referee.sv
// Volleyball-style match referee: serve, rally touch limits, ground faults,
// rally-point scoring and win detection. Define MATCH_REFEREE_WIN_BY_TWO_EN to
// require a two-point lead to win.
module match_referee
    import match_pkg::*;
#(
    parameter int SCORE_W      = 5,
    parameter int WIN_POINTS   = DEF_WIN_POINTS,
    parameter int MAX_TOUCHES  = DEF_MAX_TOUCHES,
    parameter int PAUSE_CYCLES = 65_000_000,
    parameter int NET_X        = 512
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               new_game,
    input  logic               pl1_col,
    input  logic               pl2_col,
    input  logic               gnd_col,
    input  logic [11:0]        ball_xpos,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               serve_side,
    output logic               ball_reset,
    output logic               point_flag,
    output logic               over_touch,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic               serve_q, serve_d;
    logic               point_q, point_d, over_q, over_d;

    logic               pause_load, pause_clear, pause_done;
    logic               award, award_side;
    logic               touch1, touch2;
    logic               win_c;
    logic [SCORE_W-1:0] win_score;

    pause_timer #(
        .PAUSE_CYCLES(PAUSE_CYCLES)
    ) u_pause (
        .clk_i  (pclk),
        .rst_ni (rst),
        .load_i (pause_load),
        .clear_i(pause_clear),
        .done_o (pause_done)
    );

    // A double touch in one cycle is ambiguous and is recorded for neither side.
    assign touch1 = pl1_col & ~pl2_col;
    assign touch2 = pl2_col & ~pl1_col;

    // serve_q doubles as the last point winner, which is who can have just won.
    assign win_score = (serve_q == SIDE_P1) ? score1_q : score2_q;

`ifdef MATCH_REFEREE_WIN_BY_TWO_EN
    logic [SCORE_W-1:0] lose_score;
    assign lose_score = (serve_q == SIDE_P1) ? score2_q : score1_q;
    assign win_c = ((win_score >= SCORE_W'(WIN_POINTS)) &&
                    ({1'b0, win_score} >= ({1'b0, lose_score} + (SCORE_W+1)'(2)))) ||
                   ((win_score == SCORE_MAX) && (win_score > lose_score));
`else
    assign win_c = (win_score >= SCORE_W'(WIN_POINTS));
`endif

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        serve_d     = serve_q;
        point_d     = 1'b0;
        over_d      = 1'b0;
        pause_load  = 1'b0;
        pause_clear = 1'b0;
        award       = 1'b0;
        award_side  = SIDE_P1;
        if (new_game) begin
            state_d     = ST_SERVE;
            score1_d    = '0;
            score2_d    = '0;
            cnt1_d      = '0;
            cnt2_d      = '0;
            serve_d     = SIDE_P1;
            pause_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_SERVE: begin
                    if (!gnd_col && serve_q == SIDE_P1 && touch1) begin
                        cnt1_d  = CNT_W'(1);
                        cnt2_d  = '0;
                        state_d = ST_RALLY;
                    end else if (!gnd_col && serve_q == SIDE_P2 && touch2) begin
                        cnt1_d  = '0;
                        cnt2_d  = CNT_W'(1);
                        state_d = ST_RALLY;
                    end
                end
                ST_RALLY: begin
                    if (gnd_col) begin
                        award      = 1'b1;
                        award_side = (ball_xpos < 12'(NET_X)) ? SIDE_P2 : SIDE_P1;
                    end else if (touch1) begin
                        if (cnt1_q == CNT_W'(MAX_TOUCHES)) begin
                            award      = 1'b1;
                            award_side = SIDE_P2;
                            over_d     = 1'b1;
                        end else begin
                            cnt1_d = cnt1_q + 1'b1;
                            cnt2_d = '0;
                        end
                    end else if (touch2) begin
                        if (cnt2_q == CNT_W'(MAX_TOUCHES)) begin
                            award      = 1'b1;
                            award_side = SIDE_P1;
                            over_d     = 1'b1;
                        end else begin
                            cnt2_d = cnt2_q + 1'b1;
                            cnt1_d = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_done) begin
                        state_d = win_c ? ST_OVER : ST_SERVE;
                    end
                end
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_IDLE;
            endcase
            if (award) begin
                point_d    = 1'b1;
                serve_d    = award_side;
                cnt1_d     = '0;
                cnt2_d     = '0;
                state_d    = ST_PAUSE;
                pause_load = 1'b1;
                if (award_side == SIDE_P1) begin
                    if (score1_q != SCORE_MAX) score1_d = score1_q + 1'b1;
                end else begin
                    if (score2_q != SCORE_MAX) score2_d = score2_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            score1_q <= '0;
            score2_q <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            serve_q  <= SIDE_P1;
            point_q  <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            score1_q <= score1_d;
            score2_q <= score2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            serve_q  <= serve_d;
            point_q  <= point_d;
            over_q   <= over_d;
        end
    end

    always_comb begin
        ball_reset = (state_q != ST_RALLY);
        game_over  = (state_q == ST_OVER);
        winner     = (state_q == ST_OVER) ? serve_q : 1'b0;
        score_p1   = score1_q;
        score_p2   = score2_q;
        serve_side = serve_q;
        point_flag = point_q;
        over_touch = over_q;
        state_o    = state_q;
    end

endmodule

// File: doc/match_referee.md
MATCH_REFEREE -- requirements
Module: match_referee

Interface
REQ-001 Parameter SCORE_W, default 5: score counter width.
REQ-002 Parameter WIN_POINTS, default 15: points needed to win, 1..2^SCORE_W-1.
REQ-003 Parameter MAX_TOUCHES, default 3: legal consecutive touches per side, 1..7.
REQ-004 Parameter PAUSE_CYCLES, default 65_000_000: post-point pause (1 s at 65 MHz).
REQ-005 Parameter NET_X, default 512: net x coordinate; ball_xpos < NET_X is player-1 half.
REQ-006 pclk  input  1  pixel clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 new_game  input  1  one-cycle pulse; starts a fresh match.
REQ-009 pl1_col, pl2_col  input  1 each  one-cycle pulse per player-ball touch.
REQ-010 gnd_col  input  1  one-cycle pulse when the ball hits the ground.
REQ-011 ball_xpos  input  12  ball x position, sampled in the gnd_col cycle.
REQ-012 score_p1, score_p2  output  SCORE_W each  current scores.
REQ-013 serve_side  output  1  0 = player 1 serves, 1 = player 2.
REQ-014 ball_reset  output  1  level; high while the ball must sit at the serve position.
REQ-015 point_flag, over_touch  output  1 each  one-cycle pulses: point awarded; touch-limit fault.
REQ-016 game_over  output  1  level; winner  output  1  valid while game_over is high (0 = p1).

Function
REQ-017 States: IDLE, SERVE, RALLY, PAUSE, OVER; encoding taken from the shared package.
REQ-018 IDLE -> SERVE on new_game; all other inputs are ignored in IDLE.
REQ-019 SERVE: ball_reset=1; a touch by the serving side -> RALLY with that side's count=1; a touch by the other side is ignored.
REQ-020 RALLY: a touch by a side increments its count and clears the opponent's count to 0.
REQ-021 RALLY: a count reaching MAX_TOUCHES+1 -> over_touch and point_flag pulse, point to opponent, -> PAUSE.
REQ-022 RALLY: gnd_col with ball_xpos < NET_X -> point to p2, else point to p1; point_flag pulses; -> PAUSE.
REQ-023 Pulses are registered: they appear exactly 1 cycle after the event cycle, and the scores update on the same edge.
REQ-024 Rally-point scoring: serve_side becomes the point winner.
REQ-025 PAUSE: counts PAUSE_CYCLES cycles, then goes to OVER if the win condition holds, else to SERVE.
REQ-026 Win condition: the winner's score >= WIN_POINTS; OVER asserts game_over and winner, and holds the scores.
REQ-027 Scores saturate at 2^SCORE_W-1; at saturation, win is declared on any lead >= 1.
REQ-028 Simultaneous pl1_col and pl2_col in RALLY or SERVE: no touch is recorded and counts are unchanged.
REQ-029 gnd_col has priority over touches in the same cycle.
REQ-030 new_game in any non-IDLE state: scores=0, counts=0, serve_side=0, pause counter cleared, -> SERVE next cycle; this has highest priority.

Reset
REQ-031 While rst=0: state=IDLE; scores, counts and pause counter = 0; serve_side=0; ball_reset=1; point_flag=over_touch=game_over=winner=0.
REQ-032 Reset asserted mid-rally or mid-pause aborts the match immediately; there is no resumption.
REQ-033 Reset release is synchronised to pclk by the upstream reset block; this block adds no synchroniser.

Configuration
REQ-034 Macro MATCH_REFEREE_WIN_BY_TWO_EN defined: the win condition additionally requires a lead >= 2 (the saturation rule of REQ-027 still applies).
REQ-035 Macro MATCH_REFEREE_WIN_BY_TWO_EN undefined: the win condition is reaching WIN_POINTS only; no lead comparison logic is synthesised.

Structure
REQ-036 Shared package match_pkg holds: state encoding, side constants (SIDE_P1=0, SIDE_P2=1), and the default WIN_POINTS and MAX_TOUCHES.
REQ-037 Sub-module pause_timer (load, done, width $clog2(PAUSE_CYCLES+1)) holds the PAUSE countdown; everything else stays in match_referee.

Verification
REQ-038 Test parameters: PAUSE_CYCLES=4, WIN_POINTS=3, MAX_TOUCHES=3.
REQ-039 Touch limit: new_game; p1 touches x4 in RALLY -> over_touch and point_flag 1 cycle later; score_p2=1; serve_side=1.
REQ-040 Ground fault: gnd_col with ball_xpos=100 -> score_p2+1; with ball_xpos=900 -> score_p1+1; PAUSE lasts 4 cycles, then SERVE with ball_reset=1.
REQ-041 Win by two: scores 2-2, p1 scores -> 3-2; with MATCH_REFEREE_WIN_BY_TWO_EN no game_over; without it, game_over=1, winner=0.
REQ-042 Simultaneous events: pl1_col+pl2_col in the same cycle -> counts unchanged; gnd_col+pl1_col in the same cycle -> point awarded, no touch recorded.
REQ-043 Reset mid-PAUSE: rst low for 1 cycle -> all outputs at REQ-031 values; new_game restarts at 0-0.
REQ-044 new_game during RALLY at 2-1 -> scores 0-0, state SERVE, serve_side=0 next cycle.
